// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 16-bit 5-stage pipeline: resolves load-use, shared-RAM
// structural and taken-branch hazards, and keeps stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_CYCLES = 2,
  parameter logic [3:0]  REG_NONE   = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rx_index,
  input  logic [3:0]  id_ry_index,
  input  logic        id_rx_used,
  input  logic        id_ry_used,
  input  logic [3:0]  ex_wbreg,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_ram_access,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        freeze,
  output logic [15:0] stall_count,
  output logic [7:0]  flush_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_MEM_DONE
  } state_t;

  localparam bit          MULTI_CYCLE = (MEM_CYCLES > 1);
  localparam bit          HAS_WAIT    = (MEM_CYCLES > 2);
  localparam int unsigned WAIT_INIT_I = HAS_WAIT ? (MEM_CYCLES - 2) : 0;
  localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_INIT_I);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] stall_q, stall_d;
  logic [7:0]  flush_q, flush_d;

  logic load_use;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c, freeze_c;
  logic branch_flush_c;

  // A REG_NONE destination never matches, even against a source index of 15.
  always_comb begin
    load_use = ex_mem_read && (ex_wbreg != REG_NONE) &&
               ((id_rx_used && (id_rx_index == ex_wbreg)) ||
                (id_ry_used && (id_ry_index == ex_wbreg)));
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    freeze_c       = 1'b0;
    branch_flush_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_ram_access && MULTI_CYCLE) begin
          freeze_c = 1'b1;
          wait_d   = WAIT_INIT;
          state_d  = HAS_WAIT ? ST_MEM_WAIT : ST_MEM_DONE;
        end else if (ex_branch_taken) begin
          // PC takes the branch target; a same-cycle single-cycle RAM access is absorbed by the flush.
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          branch_flush_c = 1'b1;
        end else if (mem_ram_access) begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
        end else if (load_use) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        freeze_c = 1'b1;
        wait_d   = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = ST_MEM_DONE;
        end
      end
      ST_MEM_DONE: begin
        // Load-use is not evaluated here; the held load re-checks next cycle in RUN.
        state_d = ST_RUN;
        if (ex_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          branch_flush_c = 1'b1;
        end else begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((pc_stall_c || freeze_c) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (branch_flush_c) begin
      flush_d = flush_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= 4'd0;
      stall_q <= 16'd0;
      flush_q <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc_stall     = pc_stall_c     && !rst;
  assign if_id_stall  = if_id_stall_c  && !rst;
  assign if_id_flush  = if_id_flush_c  && !rst;
  assign id_ex_bubble = id_ex_bubble_c && !rst;
  assign freeze       = freeze_c       && !rst;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: three instances (MEM_CYCLES = 1, 2, 3) share one stimulus stream;
// each check targets the instance whose configuration the scenario exercises.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] rx, ry, wb;
  logic rxu, ryu, mr, br, ram;

  logic [4:0]  o1, o2, o3;   // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, freeze}
  logic [15:0] sc1, sc2, sc3;
  logic [7:0]  fc1, fc2, fc3;

  int errors = 0;
  int checks = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [4:0] sb_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_rx_index(rx), .id_ry_index(ry), .id_rx_used(rxu),
    .id_ry_used(ryu), .ex_wbreg(wb), .ex_mem_read(mr), .ex_branch_taken(br),
    .mem_ram_access(ram), .pc_stall(o1[4]), .if_id_stall(o1[3]), .if_id_flush(o1[2]),
    .id_ex_bubble(o1[1]), .freeze(o1[0]), .stall_count(sc1), .flush_count(fc1));

  pipeline_hazard_ctrl #(.MEM_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_rx_index(rx), .id_ry_index(ry), .id_rx_used(rxu),
    .id_ry_used(ryu), .ex_wbreg(wb), .ex_mem_read(mr), .ex_branch_taken(br),
    .mem_ram_access(ram), .pc_stall(o2[4]), .if_id_stall(o2[3]), .if_id_flush(o2[2]),
    .id_ex_bubble(o2[1]), .freeze(o2[0]), .stall_count(sc2), .flush_count(fc2));

  pipeline_hazard_ctrl #(.MEM_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .id_rx_index(rx), .id_ry_index(ry), .id_rx_used(rxu),
    .id_ry_used(ryu), .ex_wbreg(wb), .ex_mem_read(mr), .ex_branch_taken(br),
    .mem_ram_access(ram), .pc_stall(o3[4]), .if_id_stall(o3[3]), .if_id_flush(o3[2]),
    .id_ex_bubble(o3[1]), .freeze(o3[0]), .stall_count(sc3), .flush_count(fc3));

  typedef struct {
    logic [3:0] rx;
    logic [3:0] ry;
    logic       rxu;
    logic       ryu;
    logic [3:0] wb;
    logic       mr;
    logic       br;
    logic [4:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [4:0] outs(input int d);
    case (d)
      1: return o1;
      2: return o2;
      default: return o3;
    endcase
  endfunction

  function automatic logic [15:0] scnt(input int d);
    case (d)
      1: return sc1;
      2: return sc2;
      default: return sc3;
    endcase
  endfunction

  function automatic logic [7:0] fcnt(input int d);
    case (d)
      1: return fc1;
      2: return fc2;
      default: return fc3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic clear_inputs();
    rx = 4'd0; ry = 4'd0; rxu = 1'b0; ryu = 1'b0;
    wb = 4'hF; mr = 1'b0; br = 1'b0; ram = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] r);
    rx = r; rxu = 1'b1; wb = r; mr = 1'b1;
  endtask

  // Inputs are already driven; expected controls enter the scoreboard, are compared at the
  // falling edge, and the counter model advances across the following rising edge.
  task automatic step(input string nm, input int d, input logic [4:0] e);
    logic [4:0] exp;
    sb_q.push_back(e);
    @(negedge clk);
    exp = sb_q.pop_front();
    chk(nm, {11'd0, outs(d)}, {11'd0, exp});
    if ((exp[4] || exp[0]) && m_stall < 16'hFFFF) m_stall++;
    if (exp[2] && br) m_flush = (m_flush + 1) % 256;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string nm, input int d);
    chk({nm, "_stall_cnt"}, scnt(d), 16'(m_stall));
    chk({nm, "_flush_cnt"}, {8'd0, fcnt(d)}, 16'(m_flush));
  endtask

  task automatic reset_all();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_stall = 0;
    m_flush = 0;
  endtask

  initial begin
    vecs[0] = '{4'd3,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0, 5'b11010, "lu_rx"};
    vecs[1] = '{4'd3,  4'd3, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 5'b00000, "lu_unused"};
    vecs[2] = '{4'd15, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 5'b00000, "regnone_rx"};
    vecs[3] = '{4'd0,  4'd9, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0, 5'b11010, "lu_ry"};
    vecs[4] = '{4'd5,  4'd0, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 5'b00000, "no_load"};
    vecs[5] = '{4'd0,  4'd0, 1'b0, 1'b0, 4'hF,  1'b0, 1'b1, 5'b00110, "branch"};
    vecs[6] = '{4'd11, 4'd0, 1'b1, 1'b0, 4'd11, 1'b1, 1'b1, 5'b00110, "branch_lu"};
    vecs[7] = '{4'd0,  4'd15,1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 5'b00000, "regnone_ry"};
    vecs[8] = '{4'd10, 4'd10,1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 5'b00000, "lu_mismatch"};
    vecs[9] = '{4'd0,  4'd0, 1'b0, 1'b0, 4'hF,  1'b0, 1'b0, 5'b00000, "idle"};

    clear_inputs();
    rst = 1'b1;
    set_lu(4'd3);
    br = 1'b1;
    ram = 1'b1;
    #12;
    chk("rst_outs_dut2", {11'd0, o2}, 16'd0);
    chk("rst_outs_dut1", {11'd0, o1}, 16'd0);
    chk("rst_stall_cnt", sc3, 16'd0);
    chk("rst_flush_cnt", {8'd0, fc2}, 16'd0);
    reset_all();

    // Load-use on MEM_CYCLES=2: one stall cycle, then clear.
    set_lu(4'd3);
    step("lu_stall", 2, 5'b11010);
    mr = 1'b0;
    step("lu_release", 2, 5'b00000);
    chk_counters("lu", 2);

    // Table of single-cycle RUN vectors (no RAM access, so every instance stays in RUN).
    for (int i = 0; i < 10; i++) begin
      rx = vecs[i].rx; ry = vecs[i].ry; rxu = vecs[i].rxu; ryu = vecs[i].ryu;
      wb = vecs[i].wb; mr = vecs[i].mr; br = vecs[i].br;
      step(vecs[i].nm, 2, vecs[i].exp);
    end
    chk_counters("table", 2);

    // MEM_CYCLES=3 RAM access; a load-use during MEM_DONE is suppressed until RUN.
    reset_all();
    ram = 1'b1;
    step("m3_freeze_run", 3, 5'b00001);
    ram = 1'b0;
    step("m3_freeze_wait", 3, 5'b00001);
    set_lu(4'd4);
    step("m3_done_lu_suppressed", 3, 5'b10100);
    step("m3_run_lu", 3, 5'b11010);
    clear_inputs();
    step("m3_idle", 3, 5'b00000);
    chk("m3_stall_cnt", sc3, 16'd4);
    chk_counters("m3", 3);

    // MEM_CYCLES=3 with a taken branch held throughout the access.
    reset_all();
    ram = 1'b1;
    br = 1'b1;
    step("m3br_freeze_run", 3, 5'b00001);
    ram = 1'b0;
    step("m3br_freeze_wait", 3, 5'b00001);
    step("m3br_done_branch", 3, 5'b00110);
    br = 1'b0;
    step("m3br_idle", 3, 5'b00000);
    chk("m3br_flush_cnt", {8'd0, fc3}, 16'd1);
    chk_counters("m3br", 3);

    // MEM_CYCLES=2: freeze one cycle, then straight to MEM_DONE.
    reset_all();
    ram = 1'b1;
    step("m2_freeze", 2, 5'b00001);
    ram = 1'b0;
    step("m2_done", 2, 5'b10100);
    step("m2_idle", 2, 5'b00000);
    chk_counters("m2", 2);

    // MEM_CYCLES=1: branch beats RAM access and load-use in the same cycle.
    reset_all();
    ram = 1'b1;
    br = 1'b1;
    set_lu(4'd7);
    step("m1_branch_all", 1, 5'b00110);
    br = 1'b0;
    step("m1_ram_over_lu", 1, 5'b10100);
    mr = 1'b0;
    step("m1_ram_only", 1, 5'b10100);
    ram = 1'b0;
    step("m1_idle", 1, 5'b00000);
    chk_counters("m1", 1);

    // Reset asserted while MEM_CYCLES=3 sits in MEM_WAIT.
    reset_all();
    ram = 1'b1;
    step("rstw_freeze_run", 3, 5'b00001);
    ram = 1'b0;
    #1;
    chk("rstw_pre_freeze", {11'd0, o3}, 16'd1);
    rst = 1'b1;
    #1;
    chk("rstw_outs_zero", {11'd0, o3}, 16'd0);
    chk("rstw_stall_cnt", sc3, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_stall = 0;
    m_flush = 0;
    ram = 1'b1;
    step("rstw_refreeze_run", 3, 5'b00001);
    ram = 1'b0;
    step("rstw_refreeze_wait", 3, 5'b00001);
    step("rstw_done", 3, 5'b10100);
    step("rstw_idle", 3, 5'b00000);
    chk_counters("rstw", 3);

    // Saturation of the stall counter under a continuous load-use.
    reset_all();
    set_lu(4'd2);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall_cnt", sc2, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_stall_hold", sc2, 16'hFFFF);
    chk("sat_outs", {11'd0, o2}, 16'b11010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
